// File: rtl/pwl_arbiter.sv
// pwl_arbiter: round-robin front end that lets NUM_REQ requesters share one
// pipelined pwl_eval instance. A tag pipeline that tracks pwl_eval's latency
// returns each result to the requester that issued it.
module pwl_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 12,
  parameter int PWL_LAT = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_x,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           pwl_x,
  input  logic [DATA_W-1:0]           pwl_y,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_y,
  output logic                        busy
);

  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One stage covers the pwl_x register, PWL_LAT stages cover pwl_eval itself.
  localparam int STAGES = PWL_LAT + 1;

  logic [ID_W-1:0]    ptr_r;
  logic [ID_W-1:0]    cand_s;
  logic [ID_W-1:0]    gnt_id_s;
  logic               xfer_s;
  logic [NUM_REQ-1:0] valid_en_s;
  logic [NUM_REQ-1:0] ready_s;
  logic [DATA_W-1:0]  x_arr_s [NUM_REQ];
  logic [STAGES-1:0]  tag_vld_r;
  logic [ID_W-1:0]    tag_id_r [STAGES];

  // Unpack the flat operand bus into one word per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign x_arr_s[gi] = req_x[gi*DATA_W +: DATA_W];
  end

  // Round-robin search from the pointer upward with wrap; the lowest offset
  // wins. The scan runs from the farthest offset down so the last hit is the winner.
  always_comb begin
    valid_en_s = enable ? req_valid : '0;
    cand_s     = '0;
    gnt_id_s   = '0;
    xfer_s     = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_s   = ID_W'((int'(ptr_r) + k) % NUM_REQ);
      gnt_id_s = valid_en_s[cand_s] ? cand_s : gnt_id_s;
      xfer_s   = xfer_s | valid_en_s[cand_s];
    end
    ready_s = xfer_s ? (NUM_REQ'(1) << gnt_id_s) : '0;
  end

  assign req_ready = ready_s;

  // On each accepted transfer, move the pointer past the winner and capture its operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= '0;
      pwl_x <= '0;
    end else if (xfer_s) begin
      ptr_r <= (gnt_id_s == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_s + ID_W'(1);
      pwl_x <= x_arr_s[gnt_id_s];
    end else begin
      ptr_r <= ptr_r;
      pwl_x <= pwl_x;
    end
  end

  // The tag pipeline follows each operand through pwl_eval so its owner is known on exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_r <= '0;
      for (int s = 0; s < STAGES; s++) begin
        tag_id_r[s] <= '0;
      end
    end else begin
      tag_vld_r   <= {tag_vld_r[STAGES-2:0], xfer_s};
      tag_id_r[0] <= gnt_id_s;
      for (int s = 1; s < STAGES; s++) begin
        tag_id_r[s] <= tag_id_r[s-1];
      end
    end
  end

  // The response strobe decodes the oldest tag, and the data registers pwl_y.
  // busy uses next-state terms: the next tag stages hold xfer_s and tag stages
  // 0..STAGES-2, and the next rsp_valid comes from the last tag stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_y     <= '0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= tag_vld_r[STAGES-1] ? (NUM_REQ'(1) << tag_id_r[STAGES-1]) : '0;
      rsp_y     <= pwl_y;
      busy      <= xfer_s | (|tag_vld_r);
    end
  end

endmodule

// File: tb/tb_pwl_arbiter.sv
// Self-checking bench for pwl_arbiter: a behavioural pwl_eval stub plus a
// transaction-level reference model (pointer, pending-response queue).
module tb_pwl_arbiter;

  localparam int N = 4;
  localparam int W = 12;
  localparam int L = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           enable = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_x = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   pwl_x;
  logic [W-1:0]   pwl_y;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_y;
  logic           busy;

  always #5 clk = ~clk;

  pwl_arbiter #(.NUM_REQ(N), .DATA_W(W), .PWL_LAT(L)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req_valid(req_valid), .req_x(req_x),
    .req_ready(req_ready), .pwl_x(pwl_x), .pwl_y(pwl_y), .rsp_valid(rsp_valid),
    .rsp_y(rsp_y), .busy(busy)
  );

  // Piecewise-linear transfer function that stands in for pwl_eval.
  function automatic logic [W-1:0] pwl_f(input logic [W-1:0] x);
    if (x < 12'd1024)      return x + (x >> 1);
    else if (x < 12'd3072) return 12'd1536 + ((x - 12'd1024) >> 2);
    else                   return 12'd2048 + ((x - 12'd3072) >> 1);
  endfunction

  // pwl_eval stub: L unreset register stages from x_in sample to y_out.
  logic [W-1:0] pst [L];
  always @(posedge clk) begin
    pst[0] <= pwl_x;
    for (int k = 1; k < L; k++) pst[k] <= pst[k-1];
  end
  assign pwl_y = pwl_f(pst[L-1]);

  // Reference model state.
  typedef struct { int due; int id; logic [W-1:0] y; } op_t;
  op_t          pend[$];
  int           m_ptr = 0;
  logic [W-1:0] m_x = '0;
  int           ecnt = 0;
  int           n_xfer = 0;
  int           n_rsp = 0;
  logic [N-1:0] last_ready;
  int           checks = 0;
  int           errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Round-robin rule: start at pointer, ascend with wrap, first valid wins.
  function automatic int model_grant(input logic en, input logic [N-1:0] v, input int p);
    if (!en) return -1;
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic check_regs();
    logic [N-1:0] exp_v;
    exp_v = '0;
    check_eq("pwl_x", pwl_x, m_x);
    check_eq("busy", busy, pend.size() != 0);
    if (pend.size() > 0 && pend[0].due == ecnt) begin
      exp_v[pend[0].id] = 1'b1;
      check_eq("rsp_y", rsp_y, pend[0].y);
      void'(pend.pop_front());
    end
    check_eq("rsp_valid", rsp_valid, exp_v);
    check_eq("rsp_onehot", $onehot0(rsp_valid), 1);
    if (rsp_valid != '0) n_rsp++;
  endtask

  // One clock: drive at negedge, check grant, advance model at posedge, check regs.
  task automatic step(input logic en, input logic [N-1:0] v);
    int g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    enable = en;
    req_valid = v;
    for (int i = 0; i < N; i++) req_x[i*W +: W] = W'($urandom_range(0, 4095));
    #1;
    g = model_grant(en, v, m_ptr);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    last_ready = req_ready;
    check_eq("req_ready", req_ready, exp_rdy);
    check_eq("ready_onehot", $onehot0(req_ready), 1);
    @(posedge clk);
    ecnt++;
    if (g >= 0) begin
      m_ptr = (g + 1) % N;
      m_x = req_x[g*W +: W];
      n_xfer++;
      pend.push_back('{ecnt + L + 1, g, pwl_f(req_x[g*W +: W])});
    end
    #1;
    check_regs();
  endtask

  // Asynchronous reset between edges; outputs must clear at once.
  task automatic do_reset(input int hold);
    #2;
    rst = 1'b1;
    enable = 1'b0;
    req_valid = '0;
    #1;
    check_eq("rst_pwl_x", pwl_x, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_y", rsp_y, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_req_ready", req_ready, 0);
    pend.delete();
    m_ptr = 0;
    m_x = '0;
    repeat (hold) @(posedge clk);
    #2;
    rst = 1'b0;
    ecnt = 0;
  endtask

  initial begin
    logic [N-1:0] seq_v[$];
    int           seq_e[$];
    int           c0;
    int           x0;

    // Single request accepted on edge 10, response only after edge 16.
    do_reset(2);
    repeat (9) step(1'b1, 4'b0000);
    step(1'b1, 4'b0001);
    check_eq("single_grant", last_ready, 4'b0001);
    for (int e = 11; e <= 18; e++) begin
      step(1'b1, 4'b0000);
      check_eq("single_rsp", rsp_valid, (ecnt == L + 11) ? 4'b0001 : 4'b0000);
    end

    // All requesting for 8 cycles: grants and responses in 0,1,2,3 order.
    do_reset(2);
    for (int k = 0; k < 16; k++) begin
      step(1'b1, (k < 8) ? 4'b1111 : 4'b0000);
      if (k < 8) check_eq("all_grant", last_ready, N'(1) << (k % N));
      if (rsp_valid != '0) begin
        seq_v.push_back(rsp_valid);
        seq_e.push_back(ecnt);
      end
    end
    check_eq("all_rsp_count", seq_v.size(), 8);
    for (int k = 0; k < seq_v.size(); k++) begin
      check_eq("all_rsp_order", seq_v[k], N'(1) << (k % N));
      check_eq("all_rsp_edge", seq_e[k], k + L + 2);
    end

    // Sparse wrap: pointer at 3, requesters 0 and 2 alternate.
    do_reset(2);
    step(1'b1, 4'b0100);
    check_eq("wrap_pre", last_ready, 4'b0100);
    step(1'b1, 4'b0101);
    check_eq("wrap_g0", last_ready, 4'b0001);
    step(1'b1, 4'b0101);
    check_eq("wrap_g2", last_ready, 4'b0100);
    step(1'b1, 4'b0101);
    check_eq("wrap_g0b", last_ready, 4'b0001);
    step(1'b1, 4'b1111);
    check_eq("wrap_ptr1", last_ready, 4'b0010);
    repeat (L + 3) step(1'b1, 4'b0000);

    // Enable drop with 3 operations in flight.
    repeat (3) step(1'b1, 4'b0111);
    c0 = n_rsp;
    repeat (L + 3) begin
      step(1'b0, 4'b1111);
      check_eq("endrop_ready", last_ready, 4'b0000);
    end
    check_eq("endrop_rsps", n_rsp - c0, 3);
    check_eq("endrop_busy", busy, 0);

    // Reset two cycles after four transfers: in-flight work is discarded.
    repeat (4) step(1'b1, 4'b1111);
    repeat (2) step(1'b1, 4'b0000);
    do_reset(2);
    c0 = n_rsp;
    repeat (L + 3) step(1'b1, 4'b0000);
    check_eq("rst_no_rsp", n_rsp - c0, 0);
    step(1'b1, 4'b0010);
    repeat (L + 2) step(1'b1, 4'b0000);
    check_eq("rst_next_rsp", n_rsp - c0, 1);

    // Randomized traffic with one-hot and conservation checks.
    do_reset(2);
    c0 = n_rsp;
    x0 = n_xfer;
    repeat (10000) step($urandom_range(0, 7) != 0, N'($urandom_range(0, 15)));
    repeat (L + 3) step(1'b1, 4'b0000);
    check_eq("xfer_vs_rsp", n_rsp - c0, n_xfer - x0);
    check_eq("final_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwl_arbiter.md
PWL_ARBITER -- requirements
Module: pwl_arbiter

Interface
- REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one pwl_eval instance.
- REQ-002 The block SHALL have parameter DATA_W, default 12, giving the fixed-point operand width (M+N of pwl_eval).
- REQ-003 The block SHALL have parameter PWL_LAT, default 5, giving the pwl_eval register stages from x_in sample to y_out update.
- REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
- REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-006 The block SHALL have port enable, input, 1 bit: when high, new requests may be granted.
- REQ-007 The block SHALL have port req_valid, input, NUM_REQ bits: per-requester operand valid.
- REQ-008 The block SHALL have port req_x, input, NUM_REQ*DATA_W bits: operand of requester i at bits [i*DATA_W +: DATA_W].
- REQ-009 The block SHALL have port req_ready, output, NUM_REQ bits: one-hot grant.
- REQ-010 The block SHALL have port pwl_x, output, DATA_W bits: registered operand driven to pwl_eval x_in.
- REQ-011 The block SHALL have port pwl_y, input, DATA_W bits: from pwl_eval y_out.
- REQ-012 The block SHALL have port rsp_valid, output, NUM_REQ bits: one-hot response strobe.
- REQ-013 The block SHALL have port rsp_y, output, DATA_W bits: response data, shared by all requesters.
- REQ-014 The block SHALL have port busy, output, 1 bit: high while any accepted operation has no response yet.

Function
- REQ-015 req_ready SHALL be combinational from req_valid, enable and the round-robin pointer, with at most one bit high, and all zero when enable=0.
- REQ-016 A transfer for requester i SHALL occur on an edge where req_valid[i] and req_ready[i] are both high; at most one transfer per cycle.
- REQ-017 Arbitration SHALL be round-robin: search starts at pointer index, ascending with wrap from NUM_REQ-1 to 0, first valid wins.
- REQ-018 On a transfer from requester g, the pointer SHALL become (g+1) mod NUM_REQ; with no transfer the pointer SHALL hold.
- REQ-019 On a transfer, pwl_x SHALL load req_x[g] on the same edge; otherwise pwl_x SHALL hold its value.
- REQ-020 A tag pipeline of PWL_LAT+1 stages, each {valid, requester id}, SHALL advance every cycle; stage 0 loads {1,g} on a transfer, else {0,x}.
- REQ-021 rsp_y SHALL register pwl_y every cycle.
- REQ-022 rsp_valid SHALL register the one-hot decode of the last tag stage every cycle: for a transfer on edge E0, rsp_valid[g]=1 for exactly the one cycle following edge E0+PWL_LAT+1, with rsp_y equal to pwl_eval's result for that operand.
- REQ-023 Back-to-back transfers on consecutive edges SHALL produce responses on consecutive cycles, in acceptance order and with no loss; throughput is 1 per cycle.
- REQ-024 busy SHALL be high when any tag stage is valid or rsp_valid is non-zero, and low otherwise.
- REQ-025 enable falling while operations are in flight SHALL stop new grants only; in-flight responses SHALL still be delivered.
- REQ-026 Requesters SHALL always accept responses; the block has no response back-pressure.

Reset
- REQ-027 While rst=1, the block SHALL clear asynchronously: pointer=0, pwl_x=0, all tag valids=0, rsp_valid=0, rsp_y=0, busy=0.
- REQ-028 Reset during in-flight operations SHALL discard them, with no rsp_valid after release; pwl_eval (unreset) pipeline contents SHALL be ignored.

Verification
- REQ-029 The bench SHALL cover a single request: PWL_LAT=5, req_valid=0001 accepted on edge 10 -> rsp_valid=0001 only in the cycle after edge 16, rsp_y equal to the pwl_eval model value.
- REQ-030 The bench SHALL cover all requesting: req_valid=1111 held for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3 -> 8 consecutive responses in the same order.
- REQ-031 The bench SHALL cover a sparse wrap: pointer=3, req_valid=0101 -> grant 0, then 2, then 0 -> pointer values after each grant: 1, 3, 1.
- REQ-032 The bench SHALL cover an enable drop: 3 operations in flight, enable=0 -> req_ready=0000, 3 responses still delivered, then busy=0.
- REQ-033 The bench SHALL cover reset mid-flight: rst pulsed 2 cycles after 4 transfers -> outputs zero immediately, no rsp_valid before the next transfer's full latency.
- REQ-034 The bench SHALL cover the one-hot checks: randomized req_valid/enable for 10k cycles -> req_ready and rsp_valid always one-hot or zero, and response count equals transfer count.
